// File: rtl/sipo_frame_ctrl_if.sv
// Parallel word handshake between the frame receiver and its consumer.
// The receiver drives data and valid; the consumer drives ready.
interface sipo_frame_ctrl_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/sipo_frame_ctrl.sv
// Serial frame receiver: start bit, MSB-first data, stop bit, valid/ready out.
// Define SIPO_FRAME_CTRL_PARITY_EN to add an even-parity bit before the stop bit.
module sipo_frame_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             clr_overrun,
    sipo_frame_ctrl_if.master word,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);
    localparam int CW = $clog2(WIDTH) + 1;

`ifdef SIPO_FRAME_CTRL_PARITY_EN
    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } state_t;
`endif

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] data_q, data_n;
    logic             valid_q, valid_n;
    logic             ovr_q, ovr_n;
    logic             ferr_n;
    logic             deliver;
    logic             stop_ok;

`ifdef SIPO_FRAME_CTRL_PARITY_EN
    logic             par_err, par_err_n;
    assign stop_ok = serial_in && !par_err;
`else
    assign stop_ok = serial_in;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
            frame_err <= 1'b0;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            data_q    <= data_n;
            valid_q   <= valid_n;
            ovr_q     <= ovr_n;
            frame_err <= ferr_n;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
            par_err   <= par_err_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        deliver = 1'b0;
        ferr_n  = 1'b0;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
        par_err_n = par_err;
`endif
        if (bit_valid) begin
            unique case (state)
                IDLE: begin
                    if (!serial_in) begin
                        state_n = DATA;
                        cnt_n   = '0;
                        shreg_n = '0;
                    end
                end
                DATA: begin
                    shreg_n = {shreg[WIDTH-2:0], serial_in};
                    cnt_n   = cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
`ifdef SIPO_FRAME_CTRL_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
`ifdef SIPO_FRAME_CTRL_PARITY_EN
                PARITY: begin
                    par_err_n = ^shreg ^ serial_in;
                    state_n   = STOP;
                end
`endif
                STOP: begin
                    deliver = stop_ok;
                    ferr_n  = !stop_ok;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // A full output register with no accept this cycle drops the new word.
    always_comb begin
        data_n  = data_q;
        valid_n = valid_q;
        ovr_n   = ovr_q && !clr_overrun;
        if (deliver) begin
            if (valid_q && !word.out_ready) begin
                ovr_n = 1'b1;
            end else begin
                data_n  = shreg;
                valid_n = 1'b1;
            end
        end else if (valid_q && word.out_ready) begin
            valid_n = 1'b0;
        end
    end

    assign word.out_data  = data_q;
    assign word.out_valid = valid_q;
    assign busy           = (state != IDLE);
    assign overrun        = ovr_q;
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Scoreboard bench for sipo_frame_ctrl: stimulus queues expected words,
// a monitor pops them on each accepted transfer.
module tb_sipo_frame_ctrl;
    localparam int WIDTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic serial_in = 1'b1;
    logic bit_valid = 1'b0;
    logic clr_overrun = 1'b0;
    logic busy, frame_err, overrun;

    sipo_frame_ctrl_if #(.WIDTH(WIDTH)) bus ();

    sipo_frame_ctrl #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .serial_in   (serial_in),
        .bit_valid   (bit_valid),
        .clr_overrun (clr_overrun),
        .word        (bus.master),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    logic [WIDTH-1:0] exp_q[$];
    int ferr_pending = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every transfer and every frame_err cycle must be expected.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(bus.out_data), 32'hdead);
                end else begin
                    check("word", 32'(bus.out_data), 32'(exp_q.pop_front()));
                end
            end
            if (frame_err) begin
                check("frame_err_expected", 32'(ferr_pending > 0), 32'd1);
                if (ferr_pending > 0) ferr_pending--;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(logic b);
        serial_in = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
        serial_in = 1'b1;
    endtask

    task automatic send_frame(logic [WIDTH-1:0] d, logic stop,
                              logic par_ok, int gap);
        send_bit(1'b0);
        repeat (gap) tick();
        for (int i = WIDTH - 1; i >= 0; i--) begin
            send_bit(d[i]);
            repeat (gap) tick();
        end
`ifdef SIPO_FRAME_CTRL_PARITY_EN
        send_bit((^d) ^ !par_ok);
        repeat (gap) tick();
`endif
        send_bit(stop);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        reset = 1'b0;
        tick();

        // Idle-level bits are ignored.
        send_bit(1'b1);
        send_bit(1'b1);
        check("idle_ones_busy", 32'(busy), 32'd0);

        // Good frame 1011.
        exp_q.push_back(4'b1011);
        send_bit(1'b0);
        check("busy_in_frame", 32'(busy), 32'd1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
`ifdef SIPO_FRAME_CTRL_PARITY_EN
        send_bit(1'b1);
`endif
        check("valid_before_stop", 32'(bus.out_valid), 32'd0);
        send_bit(1'b1);
        check("t1_valid", 32'(bus.out_valid), 32'd1);
        check("t1_data", 32'(bus.out_data), 32'hb);
        check("t1_ferr", 32'(frame_err), 32'd0);
        tick();
        check("t1_valid_drop", 32'(bus.out_valid), 32'd0);

        // Bad stop bit.
        ferr_pending++;
        send_frame(4'b1011, 1'b0, 1'b1, 0);
        check("t2_ferr", 32'(frame_err), 32'd1);
        check("t2_valid", 32'(bus.out_valid), 32'd0);
        check("t2_busy", 32'(busy), 32'd0);
        tick();
        check("t2_ferr_pulse", 32'(frame_err), 32'd0);

        // Overrun: consumer stalled across two back-to-back frames.
        bus.out_ready = 1'b0;
        exp_q.push_back(4'b1011);
        send_frame(4'b1011, 1'b1, 1'b1, 0);
        check("t3_ovr_first", 32'(overrun), 32'd0);
        send_frame(4'b0110, 1'b1, 1'b1, 0);
        check("t3_valid", 32'(bus.out_valid), 32'd1);
        check("t3_data_held", 32'(bus.out_data), 32'hb);
        check("t3_ovr", 32'(overrun), 32'd1);
        tick();
        check("t3_ovr_sticky", 32'(overrun), 32'd1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("t3_ovr_clr", 32'(overrun), 32'd0);

        // Accept of pending word coincides with delivery of the next one.
        exp_q.push_back(4'b0110);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
`ifdef SIPO_FRAME_CTRL_PARITY_EN
        send_bit(1'b0);
`endif
        check("t4_data_stable", 32'(bus.out_data), 32'hb);
        bus.out_ready = 1'b1;
        send_bit(1'b1);
        check("t4_valid", 32'(bus.out_valid), 32'd1);
        check("t4_data", 32'(bus.out_data), 32'h6);
        check("t4_ovr", 32'(overrun), 32'd0);
        tick();
        check("t4_drained", 32'(bus.out_valid), 32'd0);

        // Reset mid-frame, then a frame with idle gaps between strobes.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        reset = 1'b1;
        tick();
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_valid", 32'(bus.out_valid), 32'd0);
        check("t5_rst_data", 32'(bus.out_data), 32'd0);
        check("t5_rst_ferr", 32'(frame_err), 32'd0);
        check("t5_rst_ovr", 32'(overrun), 32'd0);
        reset = 1'b0;
        tick();
        exp_q.push_back(4'b1001);
        send_frame(4'b1001, 1'b1, 1'b1, 1);
        check("t5_valid", 32'(bus.out_valid), 32'd1);
        check("t5_data", 32'(bus.out_data), 32'h9);
        tick();

`ifdef SIPO_FRAME_CTRL_PARITY_EN
        exp_q.push_back(4'b1011);
        send_frame(4'b1011, 1'b1, 1'b1, 0);
        check("par_good", 32'(bus.out_data), 32'hb);
        tick();
        ferr_pending++;
        send_frame(4'b1011, 1'b1, 1'b0, 0);
        check("par_bad_ferr", 32'(frame_err), 32'd1);
        check("par_bad_valid", 32'(bus.out_valid), 32'd0);
        tick();
`endif

        repeat (3) tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("ferr_all_seen", 32'(ferr_pending), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sipo_frame_ctrl.md
# sipo_frame_ctrl

Frame-level receive controller built around the serial-in/parallel-out shift datapath. It qualifies incoming serial bits with a strobe and detects a start bit. It assembles WIDTH data bits MSB-first, checks the stop bit (and optionally parity), then presents each completed word on a valid/ready output with overrun and framing-error reporting. It sits between the serial pin sampler and any parallel consumer.

## Interface
- WIDTH, 4, data bits per frame (≥2)
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- serial_in  in  1  serial data, sampled only when bit_valid=1
- bit_valid  in  1  one-cycle strobe marking a valid serial bit
- out_ready  in  1  consumer accepts out_data when out_valid=1
- clr_overrun  in  1  clears sticky overrun flag
- out_data  out  WIDTH  last delivered word
- out_valid  out  1  out_data holds an unconsumed word
- busy  out  1  high whenever state≠IDLE
- frame_err  out  1  one-cycle pulse on bad stop bit (or bad parity)
- overrun  out  1  sticky; a completed word was dropped

## Operation
- States: IDLE, DATA, PARITY (only with macro), STOP. State changes only on cycles with bit_valid=1; cycles with bit_valid=0 change nothing except the handshake and clr_overrun.
- IDLE: bit with serial_in=0 (start) → DATA, bit counter=0, shift register=0. serial_in=1 ignored.
- DATA: each bit shifts left: shreg <= {shreg[WIDTH-2:0], serial_in}; counter++. On the WIDTH-th data bit → PARITY (if enabled) else STOP. First received bit ends up in out_data[WIDTH-1].
- STOP: serial_in=1 with no parity error → deliver word; serial_in=0 or parity error → frame_err=1 for one cycle, word discarded. Either way → IDLE.
- Delivery: if out_valid=1 and out_ready=0 in the delivery cycle → word dropped, overrun set, out_data unchanged. Otherwise out_data<=shreg, out_valid<=1.
- Handshake: out_valid&&out_ready with no delivery → out_valid<=0. Same-cycle accept and delivery → new word loaded, out_valid stays 1, no overrun.
- overrun: cleared by clr_overrun or reset. A set and a clear in the same cycle → set wins.
- busy: combinational decode of state≠IDLE.
- Counter is $clog2(WIDTH)+1 bits wide and never wraps within a frame.

## Timing
- Reset values: out_data=0, out_valid=0, busy=0, frame_err=0, overrun=0, state=IDLE, counter=0.
- Reset mid-frame aborts the frame with no frame_err and no delivery. It also drops a pending out_valid word.
- Latency: out_valid rises on the clock edge that samples the stop bit, visible in the following cycle. Same for frame_err and overrun.
- Back-to-back frames: a start bit strobed on the very next bit_valid after the stop bit is accepted. Minimum spacing between bit_valid strobes is 1 cycle (consecutive cycles allowed).
- out_data stays stable while out_valid=1 and out_ready=0.

## Configuration
- SIPO_FRAME_CTRL_PARITY_EN defined: PARITY state is present. One even-parity bit follows the data bits. parity_err = ^shreg ^ serial_in, latched and evaluated in STOP. Frame length is 1+WIDTH+1+1 bits.
- Undefined: no PARITY state and no parity logic. DATA goes directly to STOP. Frame length is 1+WIDTH+1 bits.

## Test plan
- WIDTH=4, strobes 0,1,0,1,1,1 (start, data 1011, stop), out_ready=1 → out_data=4'b1011, out_valid high exactly one cycle, frame_err=0.
- Same frame with stop bit=0 → frame_err one-cycle pulse, out_valid stays 0, state back to IDLE (busy=0).
- out_ready=0, two good frames 1011 then 0110 → out_data stays 1011, overrun=1. Pulse clr_overrun → overrun=0.
- Word pending; out_ready=1 on the exact stop-bit cycle of the next frame 0110 → out_data=0110, out_valid stays 1, overrun=0.
- Reset asserted after 2 data bits, then full frame 1001 → only 1001 delivered, no frame_err. All outputs 0 during reset.
- With SIPO_FRAME_CTRL_PARITY_EN: data 1011 with parity 1 → delivered. Parity 0 → frame_err pulse, no delivery.
